// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr: oversampled JTAG TAP with IDCODE, BYPASS and NumDr user data registers on a shared shift register.
module jtag_tap_multi_dr #(
  parameter int          IrLength    = 5,
  parameter int          NumDr       = 4,
  parameter int          DrWidth     = 41,
  parameter int          DrIrBase    = 'h10,
  parameter logic [31:0] IdcodeValue = 32'h00000001
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tck_i,
  input  logic                     tms_i,
  input  logic                     tdi_i,
  output logic                     tdo_o,
  output logic                     tdo_oe_o,
  output logic [IrLength-1:0]      ir_o,
  output logic                     test_logic_reset_o,
  input  logic [NumDr*DrWidth-1:0] dr_capture_data_i,
  output logic [NumDr-1:0]         dr_capture_o,
  output logic [NumDr-1:0]         dr_update_o,
  output logic [DrWidth-1:0]       dr_update_data_o
);
  localparam int SrW = DrWidth > 32 ? DrWidth : 32;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_t;
  state_t state, next_state;
  logic tck_q, rise, fall, is_id;
  logic [IrLength-1:0] ir_sr;
  logic [SrW-1:0] dr_sr, cap_val, shifted;
  logic [NumDr-1:0] sel;
  int msb;
  assign rise = tck_i & ~tck_q;
  assign fall = ~tck_i & tck_q;
  assign test_logic_reset_o = state == TLR;
  assign dr_update_data_o = dr_sr[DrWidth-1:0];
  always_comb begin
    case (state)
      TLR:     next_state = tms_i ? TLR : RTI;
      RTI:     next_state = tms_i ? SEL_DR : RTI;
      SEL_DR:  next_state = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = tms_i ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms_i ? UPD_DR : PA_DR;
      PA_DR:   next_state = tms_i ? EX2_DR : PA_DR;
      EX2_DR:  next_state = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms_i ? SEL_DR : RTI;
      SEL_IR:  next_state = tms_i ? TLR : CAP_IR;
      CAP_IR:  next_state = tms_i ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms_i ? UPD_IR : PA_IR;
      PA_IR:   next_state = tms_i ? EX2_IR : PA_IR;
      EX2_IR:  next_state = tms_i ? UPD_IR : SH_IR;
      default: next_state = tms_i ? SEL_DR : RTI;
    endcase
  end
  always_comb begin
    is_id = ir_o == IrLength'(1);
    cap_val = is_id ? SrW'(IdcodeValue) : '0;
    sel = '0;
    for (int k = 0; k < NumDr; k++) begin
      sel[k] = ir_o == IrLength'(DrIrBase + k);
      if (sel[k]) cap_val = SrW'(dr_capture_data_i[k*DrWidth +: DrWidth]);
    end
    // TDI lands on the top bit of the selected register's length; bits above it are cleared
    msb = is_id ? 31 : |sel ? DrWidth - 1 : 0;
    shifted = ((dr_sr >> 1) & ((SrW'(1) << msb) - SrW'(1))) | (SrW'(tdi_i) << msb);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= TLR;
      tck_q <= 1'b0;
      ir_o <= IrLength'(1);
      ir_sr <= '0;
      dr_sr <= '0;
      tdo_o <= 1'b0;
      tdo_oe_o <= 1'b0;
      dr_capture_o <= '0;
      dr_update_o <= '0;
    end else begin
      tck_q <= tck_i;
      dr_capture_o <= '0;
      dr_update_o <= '0;
      if (rise) begin
        state <= next_state;
        case (state)
          CAP_IR:  ir_sr <= IrLength'(1);
          SH_IR:   ir_sr <= {tdi_i, ir_sr[IrLength-1:1]};
          UPD_IR:  ir_o <= ir_sr;
          CAP_DR: begin
            dr_sr <= cap_val;
            dr_capture_o <= sel;
          end
          SH_DR:   dr_sr <= shifted;
          UPD_DR:  dr_update_o <= sel;
          default: ;
        endcase
      end
      if (fall) begin
        tdo_o <= state == SH_IR ? ir_sr[0] : state == SH_DR ? dr_sr[0] : tdo_o;
        tdo_oe_o <= state == SH_IR || state == SH_DR;
      end
      if (state == TLR) begin
        ir_o <= IrLength'(1);
        ir_sr <= '0;
      end
    end
  end
endmodule

// File: doc/jtag_tap_multi_dr.md
# jtag_tap_multi_dr

Parametrised JTAG TAP controller that runs entirely in the system clock domain and serves `NumDr` user data registers alongside IDCODE and BYPASS. TCK, TMS and TDI arrive as pre-synchronised level inputs and are oversampled; TAP activity advances only on detected TCK edges. Each user channel gets a capture-data input, a one-cycle capture strobe and a one-cycle update strobe. Debug transport modules (DTMCS, DMI and similar) attach without owning any TAP logic.

## Interface
- `IrLength`, default 5: IR width in bits, minimum 3.
- `NumDr`, default 4: number of user data registers, minimum 1.
- `DrWidth`, default 41: width of every user DR, minimum 2.
- `DrIrBase`, default 'h10: IR code of user channel 0; channel k uses `DrIrBase+k`. Constraint: `DrIrBase >= 2` and `DrIrBase+NumDr-1 < 2**IrLength-1`.
- `IdcodeValue`, default 32'h00000001: IDCODE value, bit 0 = 1.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, **synchronous, active-high**. Single clock domain.
- `tck_i`  in  1  sampled TCK level, already synchronised to `clk_i`.
- `tms_i`  in  1  sampled TMS.
- `tdi_i`  in  1  sampled TDI.
- `tdo_o`  out  1  TDO.
- `tdo_oe_o`  out  1  TDO output enable.
- `ir_o`  out  IrLength  current instruction.
- `test_logic_reset_o`  out  1  high while in TestLogicReset.
- `dr_capture_data_i`  in  NumDr*DrWidth  parallel capture value; channel k occupies `[k*DrWidth +: DrWidth]`.
- `dr_capture_o`  out  NumDr  one-cycle pulse per channel, on capture.
- `dr_update_o`  out  NumDr  one-cycle pulse per channel, on update.
- `dr_update_data_o`  out  DrWidth  shift-register contents; valid while any `dr_update_o` bit is high.

## Operation
- **Edge detection.** Register `tck_q`.
  - rise = `tck_i & ~tck_q`.
  - fall = `~tck_i & tck_q`.
  - All TAP state changes occur on the `clk_i` edge of a rise cycle. TMS and TDI are sampled in that same cycle.
- **FSM.** The standard 16-state IEEE 1149.1 FSM: TestLogicReset, RunTestIdle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for both DR and IR.
  - Transitions are per the standard, taken only on rise.
  - Five rises with TMS=1 reach TestLogicReset from any state.
- **IR handling.**
  - CaptureIr loads the shift register with `{zeros, 2'b01}`.
  - ShiftIr shifts right, with TDI entering the MSB.
  - UpdateIr copies the shift register to `ir_o`.
  - In TestLogicReset, `ir_o` = 1 (IDCODE) and the IR shift register = 0.
- **DR select by `ir_o`.**
  - 1: IDCODE.
  - `DrIrBase+k`: user channel k.
  - Any other code, including 0 and all-ones: BYPASS.
- **DR handling.** A single shared DR shift register of width `max(DrWidth,32)`, LSB first.
  - CaptureDr loads `IdcodeValue`, `dr_capture_data_i` slice k, or 0 for BYPASS.
  - ShiftDr shifts right with TDI entering the MSB of the active length: bit 31 for IDCODE, bit `DrWidth-1` for a user channel, bit 0 for BYPASS.
- **Strobes.**
  - `dr_capture_o[k]` pulses when a CaptureDr rise occurs with channel k selected.
  - `dr_update_o[k]` pulses when an UpdateDr rise occurs with channel k selected.
  - IDCODE and BYPASS produce no strobes.
- **TDO.** Updated only on fall.
  - `tdo_o` takes bit 0 of the IR shift register in ShiftIr, and bit 0 of the DR shift register in ShiftDr. In all other states `tdo_o` holds its value.
  - `tdo_oe_o` = (state is ShiftIr or ShiftDr), evaluated on the same fall.
- **Precedence.**
  - `rst_i` overrides everything.
  - TestLogicReset clears IR and strobes regardless of TMS.

## Timing
- **Reset values** (all outputs, one `clk_i` after `rst_i`):
  - state = TestLogicReset, `ir_o` = 1, `tck_q` = 0.
  - `tdo_o` = 0, `tdo_oe_o` = 0.
  - `dr_capture_o` = 0, `dr_update_o` = 0.
  - `test_logic_reset_o` = 1, `dr_update_data_o` = 0.
- **Assertion of `rst_i` mid-scan** aborts the scan: no update strobe, and the shift register contents are discarded.
- **Input timing.** TCK high and low phases must each last ≥ 2 `clk_i` cycles; shorter pulses are undefined.
- **Strobe latency.** `dr_capture_o` and `dr_update_o` are registered.
  - Each is high for exactly one cycle, the cycle immediately after the rise edge.
  - `dr_update_data_o` is stable during the `dr_update_o` cycle and is held until the next CaptureDr.
- **Capture sampling.** `dr_capture_data_i` is sampled in the CaptureDr rise cycle.
- **TDO latency.** `tdo_o` changes one `clk_i` after the fall cycle.
- **Pause.** PauseDr and PauseIr hold the shift registers indefinitely. Exit2→Shift resumes shifting without a reload.
- **Zero-shift path.** Capture→Exit1→Update with no Shift states updates with the captured value.

## Test plan
- **Reset / IDCODE.** Pulse `rst_i`, go to RunTestIdle, then run a 32-bit DR scan with TDI=0. Expect TDO = 32'h00000001 LSB first, and `tdo_oe_o` high only during ShiftDr.
- **IR capture and select.** Run an IR scan shifting in 'h12. Expect TDO to return 5'b00001 LSB first and `ir_o` = 'h12 after UpdateIr.
- **User channel.** With `ir_o` = 'h12 and channel 2 capture data = 41'h1_2345_6789_A, run a 41-bit DR scan shifting in 41'h0_DEAD_BEEF_5.
  - TDO returns the capture data.
  - `dr_capture_o` = 4'b0100 for one cycle.
  - `dr_update_o` = 4'b0100 for one cycle with `dr_update_data_o` = 41'h0_DEAD_BEEF_5.
- **BYPASS.** Set IR = 'h1F and shift 8 bits 8'hA5. Expect TDO = 0 followed by A5 delayed by one bit, and no strobes.
- **Pause and TLR.**
  - Enter PauseDr mid-scan for 10 TCKs, then resume. Expect the data to be intact.
  - Then apply 5 TMS=1 rises. Expect `test_logic_reset_o` = 1 and `ir_o` = 1.
- **Reset mid-shift.** Assert `rst_i` during ShiftDr on channel 0. Expect no `dr_update_o` pulse, state = TestLogicReset, and `tdo_oe_o` = 0.
